// File: rtl/arith_pkg.sv
// arith_pkg: FSM encodings and width limits shared by the arithmetic lab blocks
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_t;

   localparam int W_MIN = 2;
   localparam int W_MAX = 16;

   // step counter width: ceil(log2 w) + 1 bits
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// div_step: one restoring trial subtract built from a ripple of full adders
module myFA (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module div_step #(
   parameter int W = 4
) (
   input  logic [W:0]   a,
   input  logic [W-1:0] d,
   output logic [W-1:0] a_next,
   output logic         q_bit
);
   logic [W:0] nd;
   logic [W:0] c;
   logic [W:0] t;

   // a - d as a + ~d + 1 in W+1 bits
   assign nd   = ~{1'b0, d};
   assign c[0] = 1'b1;

   genvar i;
   for (i = 0; i < W; i++) begin : g_fa
      myFA u_fa (
         .a  (a[i]),
         .b  (nd[i]),
         .ci (c[i]),
         .s  (t[i]),
         .co (c[i+1])
      );
   end

   // top cell only needs its sum bit: the sign of the trial difference
   assign t[W] = a[W] ^ nd[W] ^ c[W];

   // a non-negative difference is kept; otherwise the old value is restored
   assign q_bit  = ~t[W];
   assign a_next = q_bit ? t[W-1:0] : a[W-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned W-bit divider, one restoring step per clock
module seq_restoring_divider
   import arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);
   localparam int CW = cnt_width(W);

   if (W < W_MIN || W > W_MAX) begin : g_bad_w
      $error("seq_restoring_divider: W out of range");
   end

   div_state_t  state_q, state_d;
   // partial remainder stays below the divisor after every step, so its
   // W+1-bit form only exists transiently as the shifted value a_sh
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] q_q, q_d;
   logic [W-1:0] dvs_q, dvs_d;
   logic [W-1:0] quo_q, quo_d;
   logic [W-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         dbz_q, dbz_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [W:0]   a_sh;
   logic [W-1:0] step_a;
   logic         step_bit;

   assign a_sh = {1'b0, a_q, q_q[W-1]};

   div_step #(.W(W)) u_step (
      .a      (a_sh),
      .d      (dvs_q),
      .a_next (step_a),
      .q_bit  (step_bit)
   );

   // next-state: iterate in RUN, accept new operations in IDLE or DONE
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      if (state_q == RUN) begin
         a_d   = step_a;
         q_d   = {q_q[W-2:0], step_bit};
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(W - 1)) begin
            quo_d   = q_d;
            rem_d   = a_d;
            dbz_d   = 1'b0;
            state_d = DONE;
         end
      end else if (start) begin
         if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
         end else begin
            a_d     = '0;
            q_d     = dividend;
            dvs_d   = divisor;
            cnt_d   = '0;
            state_d = RUN;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // state, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Sequential unsigned divider forming the inverse of the 4×4 combinational array multiplier in the arithmetic datapath lab set. It takes a W-bit dividend and divisor and produces a W-bit quotient and remainder using one restoring shift-subtract step per clock. A start/busy/done handshake frames each operation. Results are held until the next accepted start, so a testbench can check `dividend = quotient*divisor + remainder` by feeding the outputs straight into the multiplier.

## Interface
- `W`, default 4: operand width. Legal range is 2..16.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request. Sampled only when `busy`=0.
- `dividend`  input  W  numerator. Captured on the accepted start.
- `divisor`  input  W  denominator. Captured on the accepted start.
- `busy`  output  1  high while iterations are in progress.
- `done`  output  1  one-cycle pulse when the results become valid.
- `quotient`  output  W  result, held until the next accepted start.
- `remainder`  output  W  result, held until the next accepted start.
- `div_by_zero`  output  1  flags that the last accepted operation had divisor = 0. Held with the results.

## Operation
- **FSM states**
  - IDLE, RUN, DONE.
  - Encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- **IDLE**
  - `start`=1 with divisor≠0: load A (partial remainder, W+1 bits) = 0 and Q = dividend, latch the divisor, clear the step counter, then go to RUN.
  - `start`=1 with divisor=0: set quotient = all ones and remainder = dividend, set `div_by_zero`=1, then go to DONE.
- **RUN** (one step per cycle)
  - Shift {A,Q} left by 1.
  - T = A − {1'b0,divisor}, computed in W+1 bits.
  - If T is non-negative (MSB=0): A←T and Q[0]←1. Otherwise A is kept and Q[0]←0.
  - After W steps: quotient←Q, remainder←A[W-1:0], `div_by_zero`←0, then go to DONE.
- **DONE**
  - `done`=1 for this single cycle.
  - `start`=1 here is accepted exactly as in IDLE; the divisor=0 check applies the same way.
  - With no start, go to IDLE.
- `start` while in RUN is ignored. No queuing.
- Operand inputs may change freely after the accepted cycle; only the captured values are used.
- **Arithmetic**: all unsigned.
  - The remainder is always less than the divisor.
  - dividend < divisor gives quotient=0, remainder=dividend.
- **Reset** (asserted asynchronously, including mid-RUN): state=IDLE. `busy`, `done`, `quotient`, `remainder`, `div_by_zero`, A, Q and the counter all go to 0. The operation in flight is discarded.

## Timing
- Start accepted at rising edge k (divisor≠0):
  - `busy`=1 for cycles k+1 … k+W.
  - `done`=1 in cycle k+W+1 only.
  - `quotient`/`remainder` become valid at edge k+W and stay stable from cycle k+W+1.
  - Latency is W+1 cycles; for W=4, `done` rises 5 cycles after start.
- Start accepted at edge k with divisor=0:
  - `busy` stays 0.
  - `done` and `div_by_zero` are 1 in cycle k+1.
- Back-to-back: a start held high through DONE is accepted on that edge, giving a new `done` every W+1 cycles.
- `busy` and `done` are never 1 in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `arith_pkg`: FSM state encodings and the W range limits, reused by the other arithmetic lab blocks.
- Sub-module `div_step`: combinational W+1-bit trial subtract.
  - Inputs: A and the divisor.
  - Outputs: next A and the quotient bit.
  - Built as a ripple of `myFA` cells so the gate-level style matches the multiplier.
- Top level: the FSM, counter (ceil(log2 W)+1 bits), A/Q/divisor registers and output registers.

## Test plan
- 13/3, W=4, start at edge k → `done` in cycle k+5; quotient=4, remainder=1, `div_by_zero`=0, `busy` high for exactly 4 cycles.
- 15/1 → quotient=15, remainder=0. 5/7 → quotient=0, remainder=5.
- 9/0 → `done` in cycle k+1; quotient=15, remainder=9, `div_by_zero`=1, `busy` never high. A following 8/2 gives 4, 0 with `div_by_zero`=0.
- `start` pulsed with 6/4 during RUN of 14/5 → ignored. Results are 2, 4, and only one `done`.
- `rst_n` low during cycle k+2 of 12/5 → all outputs 0 immediately, state IDLE. A new 12/5 started after reset releases gives 2, 2.
- Exhaustive sweep of all 256 operand pairs, back-to-back starts → every result matches the reference model. Each nonzero-divisor result also satisfies quotient*divisor + remainder = dividend when checked through the 4×4 multiplier.
